id_ex_stage: RTL

//  Decode->Execute pipeline register plus load-use/branch hazard control for the 5-stage RV32I core.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register with load-use stall / redirect flush control
// and saturating stall/flush event counters for performance debug.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ValidD,
   input  logic [XLEN-1:0]  RD1D,
   input  logic [XLEN-1:0]  RD2D,
   input  logic [XLEN-1:0]  PCD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic [XLEN-1:0]  ImmExtD,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             RegWriteD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic [1:0]       ResultSrcD,
   input  logic [3:0]       ALUControlD,
   input  logic             PCSrcE,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [4:0]       RdE,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             JumpE,
   output logic             BranchE,
   output logic             ALUSrcE,
   output logic [1:0]       ResultSrcE,
   output logic [3:0]       ALUControlE,
   output logic             ValidE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [1:0]      result_src;
      logic [3:0]      alu_control;
      logic            valid;
   } e_t;

   e_t               e_q, e_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lw_stall;

   // A load in E whose destination is read by the real instruction in D.
   always_comb begin
      lw_stall = e_q.valid & (e_q.result_src == 2'b01) & (e_q.rd != 5'd0) & ValidD &
                 ((e_q.rd == Rs1D) | (e_q.rd == Rs2D));
      StallF   = lw_stall & ~PCSrcE;
      StallD   = lw_stall & ~PCSrcE;
      FlushD   = PCSrcE;
      FlushE   = lw_stall | PCSrcE;
   end

   always_comb begin
      e_d = '0;
      if (!FlushE) begin
         e_d.rd1      = RD1D;
         e_d.rd2      = RD2D;
         e_d.pc       = PCD;
         e_d.pc_plus4 = PCPlus4D;
         e_d.imm      = ImmExtD;
         e_d.rs1      = Rs1D;
         e_d.rs2      = Rs2D;
         e_d.rd       = RdD;
         e_d.valid    = ValidD;
         // An empty D slot carries no side effects into E.
         if (ValidD) begin
            e_d.reg_write   = RegWriteD;
            e_d.mem_write   = MemWriteD;
            e_d.jump        = JumpD;
            e_d.branch      = BranchD;
            e_d.alu_src     = ALUSrcD;
            e_d.result_src  = ResultSrcD;
            e_d.alu_control = ALUControlD;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (PCSrcE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q         <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         e_q         <= e_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign RD1E        = e_q.rd1;
   assign RD2E        = e_q.rd2;
   assign PCE         = e_q.pc;
   assign PCPlus4E    = e_q.pc_plus4;
   assign ImmExtE     = e_q.imm;
   assign Rs1E        = e_q.rs1;
   assign Rs2E        = e_q.rs2;
   assign RdE         = e_q.rd;
   assign RegWriteE   = e_q.reg_write;
   assign MemWriteE   = e_q.mem_write;
   assign JumpE       = e_q.jump;
   assign BranchE     = e_q.branch;
   assign ALUSrcE     = e_q.alu_src;
   assign ResultSrcE  = e_q.result_src;
   assign ALUControlE = e_q.alu_control;
   assign ValidE      = e_q.valid;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
